// File: rtl/instruction_aligner.sv
// -----------------------------------------------------------------------------
// instruction_aligner
//
// Fetch-side stage that sits in front of the decompressor. It issues
// word-aligned reads to instruction memory and buffers the returned halfwords
// in a 4-entry queue. It presents one instruction per handshake, aligned to
// bit 0:
//   - a 16-bit compressed instruction, zero-extended, or
//   - a full 32-bit instruction, which may straddle two memory words.
// It also tracks the PC of the presented instruction and handles redirects,
// including redirects to halfword-aligned targets.
//
// Handshakes:
//   Output side: an instruction transfers on a rising edge where
//   instr_valid && instr_ready, unless redirect_valid is high in that cycle.
//   Memory side: every fetch_req is accepted, and fetch_rvalid answers it
//   exactly one cycle later.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous active-low reset
//   fetch_req         read request to instruction memory
//   fetch_addr[31:0]  word address of the request (bits [1:0] = 00)
//   fetch_rdata[31:0] returned word; [15:0] is the lower-addressed halfword
//   fetch_rvalid      fetch_rdata valid
//   instr_out[31:0]   aligned instruction ({16'h0, hw} when compressed)
//   instr_pc[31:0]    byte address of instr_out
//   instr_compressed  instr_out is a 16-bit instruction
//   instr_valid       instr_out / instr_pc / instr_compressed valid
//   instr_ready       downstream accepts
//   redirect_valid    flush and restart at redirect_pc
//   redirect_pc[31:0] new PC (bit 0 ignored)
// -----------------------------------------------------------------------------
module instruction_aligner #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_req,
  output logic [31:0] fetch_addr,
  input  logic [31:0] fetch_rdata,
  input  logic        fetch_rvalid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_compressed,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  // Halfword queue; q[0] is the head (oldest halfword).
  logic [15:0] q [4];
  logic [2:0]  count;
  logic        pend;      // one fetch outstanding; its response is due this cycle
  logic        drop_low;  // next response starts at its upper halfword

  logic [15:0] q_n [4];
  logic [2:0]  count_n;
  logic [2:0]  count_after;
  logic [1:0]  consume;
  logic        head_is32;
  logic        xfer;
  logic        take_resp;

  // Presentation straight from the queue head.
  always_comb begin
    head_is32        = (q[0][1:0] == 2'b11);
    instr_valid      = 1'b0;
    instr_out        = 32'h0;
    instr_compressed = 1'b0;
    if (count != 3'd0) begin
      if (!head_is32) begin
        instr_valid      = 1'b1;
        instr_out        = {16'h0, q[0]};
        instr_compressed = 1'b1;
      end else if (count >= 3'd2) begin
        instr_valid = 1'b1;
        instr_out   = {q[1], q[0]};
      end
    end
  end

  // Consume, fetch issue and response acceptance.
  always_comb begin
    xfer        = instr_valid && instr_ready && !redirect_valid;
    consume     = xfer ? (head_is32 ? 2'd2 : 2'd1) : 2'd0;
    count_after = count - {1'b0, consume};
    // The in-flight word counts as two halfwords already, so the queue can
    // never overflow when the response lands.
    fetch_req   = rst && !redirect_valid &&
                  ((count_after + (pend ? 3'd2 : 3'd0)) <= 3'd2);
    take_resp   = fetch_rvalid && pend && !redirect_valid;
  end

  // Next queue contents: pop from the head first, then append at the tail.
  always_comb begin
    q_n = q;
    case (consume)
      2'd1: begin
        q_n[0] = q[1];
        q_n[1] = q[2];
        q_n[2] = q[3];
        q_n[3] = 16'h0;
      end
      2'd2: begin
        q_n[0] = q[2];
        q_n[1] = q[3];
        q_n[2] = 16'h0;
        q_n[3] = 16'h0;
      end
      default: ;
    endcase
    count_n = count_after;
    if (take_resp) begin
      if (drop_low) begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) == count_after) q_n[i] = fetch_rdata[31:16];
        end
        count_n = count_after + 3'd1;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (3'(i) == count_after)        q_n[i] = fetch_rdata[15:0];
          if (3'(i) == count_after + 3'd1) q_n[i] = fetch_rdata[31:16];
        end
        count_n = count_after + 3'd2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q          <= '{default: 16'h0};
      count      <= 3'd0;
      pend       <= 1'b0;
      drop_low   <= PC_RESET[1];
      fetch_addr <= PC_RESET & 32'hFFFF_FFFC;
      instr_pc   <= PC_RESET & 32'hFFFF_FFFE;
    end else if (redirect_valid) begin
      // Redirect wins: a response or transfer in this cycle is dropped.
      count      <= 3'd0;
      pend       <= 1'b0;
      drop_low   <= redirect_pc[1];
      fetch_addr <= redirect_pc & 32'hFFFF_FFFC;
      instr_pc   <= redirect_pc & 32'hFFFF_FFFE;
    end else begin
      q     <= q_n;
      count <= count_n;
      pend  <= fetch_req;
      if (take_resp && drop_low) drop_low <= 1'b0;
      if (fetch_req) fetch_addr <= fetch_addr + 32'd4;
      if (xfer)      instr_pc   <= instr_pc + (head_is32 ? 32'd4 : 32'd2);
    end
  end

endmodule
